// File: rtl/oib_pkg.sv
// Shared command/response codes, FSM state encoding and parity helper for the
// far-end target of the outbound/inbound byte bus.
package oib_pkg;

  localparam logic [7:0] OIB_CMD_WR    = 8'h01;
  localparam logic [7:0] OIB_CMD_RD    = 8'h02;
  localparam logic [7:0] OIB_RSP_WACK  = 8'h80;
  localparam logic [7:0] OIB_RSP_RDATA = 8'h81;
  localparam logic [7:0] OIB_RSP_ERR   = 8'hFF;
  localparam logic [7:0] OIB_IDLE      = 8'h00;

  localparam int OIB_Q_DEPTH = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    EXEC  = 3'd3,
    ERR   = 3'd4,
    RESP  = 3'd5
  } oib_state_e;

  // Even parity bit: the value that makes ^{b, bit} == 0.
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/oib_edge_sync.sv
// Synchronises the asynchronous oib_clk strobe into the block clock domain and
// emits a one-cycle registered pulse on each synchronised rising edge.
module oib_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic stb_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   stb_q;

  // Synchroniser chain, previous-level flop and registered rising-edge pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      last_q <= 1'b0;
      stb_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      last_q <= sync_q[SYNC_STAGES-1];
      stb_q  <= sync_q[SYNC_STAGES-1] & ~last_q;
    end
  end

  assign stb_o = stb_q;

endmodule

// File: rtl/oib_target.sv
// Far-end target of the outbound/inbound byte bus: decodes read/write frames
// against a small 32-bit register file and paces responses on the same strobe.
module oib_target
  import oib_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       ext_clk,
  input  logic       ext_rst_n,
  input  logic       oib_clk,
  input  logic [7:0] ob_data,
  input  logic       ob_pty,
  output logic [7:0] ib_data,
  output logic       ib_pty,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  oib_state_e          state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0]   addr_idx_q, addr_idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [7:0]          rq_q [OIB_Q_DEPTH];
  logic [7:0]          rq_d [OIB_Q_DEPTH];
  logic [2:0]          rq_cnt_q, rq_cnt_d;
  logic [7:0]          ib_data_q, ib_data_d;
  logic                ib_pty_q;
  logic                busy_q;
  logic [7:0]          err_q, err_d;
  logic [31:0]         mem_q [DEPTH];

  logic                stb_s;
  logic                par_ok_s;
  logic                mem_we_s;
  logic [31:0]         rd_word_s;

  oib_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk_i  (ext_clk),
    .rst_ni (ext_rst_n),
    .async_i(oib_clk),
    .stb_o  (stb_s)
  );

  assign par_ok_s  = (even_par(ob_data) == ob_pty);
  assign rd_word_s = mem_q[addr_idx_q];

  // Frame decode, response queue management and inbound byte selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_wr_d   = cmd_wr_q;
    addr_idx_d = addr_idx_q;
    wdata_d    = wdata_q;
    rq_d       = rq_q;
    rq_cnt_d   = rq_cnt_q;
    ib_data_d  = ib_data_q;
    err_d      = err_q;
    mem_we_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (stb_s) begin
          if (!par_ok_s) begin
            state_d = ERR;
          end else if (ob_data == OIB_IDLE) begin
            state_d = IDLE;
          end else if ((ob_data == OIB_CMD_WR) || (ob_data == OIB_CMD_RD)) begin
            cmd_wr_d = (ob_data == OIB_CMD_WR);
            cnt_d    = 2'd0;
            state_d  = ADDR;
          end else begin
            state_d = ERR;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ADDR: begin
        if (stb_s) begin
          if (!par_ok_s) begin
            state_d = ERR;
          end else begin
            // Only A0 selects a word; A1..A3 alias onto the same entries.
            if (cnt_q == 2'd0) begin
              addr_idx_d = ob_data[ADDR_W-1:0];
            end else begin
              addr_idx_d = addr_idx_q;
            end
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_d = cmd_wr_q ? WDATA : EXEC;
            end else begin
              state_d = ADDR;
            end
          end
        end else begin
          state_d = ADDR;
        end
      end

      WDATA: begin
        if (stb_s) begin
          if (!par_ok_s) begin
            state_d = ERR;
          end else begin
            wdata_d = {ob_data, wdata_q[31:8]};
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_d = EXEC;
            end else begin
              state_d = WDATA;
            end
          end
        end else begin
          state_d = WDATA;
        end
      end

      EXEC: begin
        for (int i = 0; i < OIB_Q_DEPTH; i++) begin
          rq_d[i] = OIB_IDLE;
        end
        if (cmd_wr_q) begin
          mem_we_s = 1'b1;
          rq_d[0]  = OIB_RSP_WACK;
          rq_cnt_d = 3'd1;
        end else begin
          rq_d[0]  = OIB_RSP_RDATA;
          rq_d[1]  = rd_word_s[7:0];
          rq_d[2]  = rd_word_s[15:8];
          rq_d[3]  = rd_word_s[23:16];
          rq_d[4]  = rd_word_s[31:24];
          rq_cnt_d = 3'd5;
        end
        state_d = RESP;
      end

      ERR: begin
        for (int i = 0; i < OIB_Q_DEPTH; i++) begin
          rq_d[i] = OIB_IDLE;
        end
        rq_d[0]  = OIB_RSP_ERR;
        rq_cnt_d = 3'd1;
        err_d    = (err_q == 8'hFF) ? err_q : (err_q + 8'd1);
        state_d  = RESP;
      end

      RESP: begin
        state_d = RESP;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A strobe landing in EXEC/ERR pops the freshly loaded queue like a RESP strobe.
    if (stb_s && (state_q inside {EXEC, ERR, RESP})) begin
      if (rq_cnt_d != 3'd0) begin
        ib_data_d = rq_d[0];
        for (int i = 0; i < OIB_Q_DEPTH - 1; i++) begin
          rq_d[i] = rq_d[i+1];
        end
        rq_d[OIB_Q_DEPTH-1] = OIB_IDLE;
        rq_cnt_d = rq_cnt_d - 3'd1;
      end else begin
        ib_data_d = OIB_IDLE;
        state_d   = IDLE;
      end
    end else begin
      ib_data_d = ib_data_q;
    end
  end

  // FSM, frame collection, response queue and registered outputs.
  always_ff @(posedge ext_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      cmd_wr_q   <= 1'b0;
      addr_idx_q <= '0;
      wdata_q    <= 32'h0000_0000;
      for (int i = 0; i < OIB_Q_DEPTH; i++) begin
        rq_q[i] <= 8'h00;
      end
      rq_cnt_q  <= 3'd0;
      ib_data_q <= 8'h00;
      ib_pty_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_wr_q   <= cmd_wr_d;
      addr_idx_q <= addr_idx_d;
      wdata_q    <= wdata_d;
      rq_q       <= rq_d;
      rq_cnt_q   <= rq_cnt_d;
      ib_data_q  <= ib_data_d;
      ib_pty_q   <= even_par(ib_data_d);
      busy_q     <= (state_d != IDLE);
      err_q      <= err_d;
    end
  end

  // Register file; a write commits only from EXEC, so aborted frames never land.
  always_ff @(posedge ext_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (mem_we_s) begin
      mem_q[addr_idx_q] <= wdata_q;
    end
  end

  assign ib_data   = ib_data_q;
  assign ib_pty    = ib_pty_q;
  assign busy      = busy_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_oib_target.sv
// Self-checking bench for oib_target: a frame-level model predicts the inbound
// byte, busy and error count after every outbound strobe; outputs are compared each cycle.
module tb_oib_target;

  logic       ext_clk;
  logic       ext_rst_n;
  logic       oib_clk;
  logic [7:0] ob_data;
  logic       ob_pty;
  logic [7:0] ib_data;
  logic       ib_pty;
  logic       busy;
  logic [7:0] err_count;

  oib_target #(
    .ADDR_W(4),
    .SYNC_STAGES(2)
  ) dut (
    .ext_clk  (ext_clk),
    .ext_rst_n(ext_rst_n),
    .oib_clk  (oib_clk),
    .ob_data  (ob_data),
    .ob_pty   (ob_pty),
    .ib_data  (ib_data),
    .ib_pty   (ib_pty),
    .busy     (busy),
    .err_count(err_count)
  );

  initial ext_clk = 1'b0;
  always #5 ext_clk = ~ext_clk;

  // Model state: bytes of the frame being collected, pending response bytes, word store.
  logic [7:0]  frame [$];
  logic [7:0]  rq [$];
  logic [31:0] mem [16];
  bit          m_resp;
  logic [7:0]  exp_ib;
  logic        exp_busy;
  logic [7:0]  exp_err;

  bit          check_en;
  int          n_cmp;
  int          n_bad;

  bit          lit_req;
  int          lit_sel;
  logic [7:0]  lit_exp;
  string       lit_name;

  task automatic model_reset();
    frame.delete();
    rq.delete();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    m_resp   = 1'b0;
    exp_ib   = 8'h00;
    exp_busy = 1'b0;
    exp_err  = 8'h00;
  endtask

  task automatic model_err();
    frame.delete();
    rq.delete();
    rq.push_back(8'hFF);
    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    m_resp = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad);
    logic [3:0] idx;
    if (m_resp) begin
      if (rq.size() > 0) begin
        exp_ib = rq.pop_front();
      end else begin
        exp_ib = 8'h00;
        m_resp = 1'b0;
      end
    end else if (bad) begin
      model_err();
    end else if (frame.size() == 0) begin
      if (b == 8'h01 || b == 8'h02) frame.push_back(b);
      else if (b != 8'h00) model_err();
    end else begin
      frame.push_back(b);
      idx = frame[1][3:0];
      if (frame[0] == 8'h02 && frame.size() == 5) begin
        rq.delete();
        rq.push_back(8'h81);
        for (int k = 0; k < 4; k++) rq.push_back(8'((mem[idx] >> (8 * k)) & 32'hFF));
        frame.delete();
        m_resp = 1'b1;
      end else if (frame[0] == 8'h01 && frame.size() == 9) begin
        mem[idx] = {frame[8], frame[7], frame[6], frame[5]};
        rq.delete();
        rq.push_back(8'h80);
        frame.delete();
        m_resp = 1'b1;
      end
    end
    exp_busy = m_resp || (frame.size() > 0);
  endtask

  // Per-cycle comparison against the model, plus one-shot literal checks.
  always @(negedge ext_clk) begin
    if (check_en && ext_rst_n) begin
      n_cmp++;
      if (ib_data !== exp_ib || ib_pty !== (^exp_ib) || busy !== exp_busy || err_count !== exp_err) begin
        n_bad++;
        if (n_bad < 20)
          $display("FAIL model t=%0t got ib=%02h pty=%0b busy=%0b err=%02h, want ib=%02h pty=%0b busy=%0b err=%02h",
                   $time, ib_data, ib_pty, busy, err_count, exp_ib, ^exp_ib, exp_busy, exp_err);
      end
    end
    if (lit_req) begin
      logic [7:0] act;
      case (lit_sel)
        0:       act = ib_data;
        1:       act = {7'd0, busy};
        2:       act = err_count;
        default: act = {7'd0, ib_pty};
      endcase
      n_cmp++;
      if (act !== lit_exp) begin
        n_bad++;
        $display("FAIL %s got %02h want %02h", lit_name, act, lit_exp);
      end
    end
  end

  task automatic expect_lit(input string nm, input int sel, input logic [7:0] e);
    lit_name = nm;
    lit_sel  = sel;
    lit_exp  = e;
    lit_req  = 1'b1;
    @(negedge ext_clk);
    #1;
    lit_req  = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit bad);
    ob_data = b;
    ob_pty  = (^b) ^ bad;
    repeat (4) @(posedge ext_clk);
    #1;
    oib_clk  = 1'b1;
    check_en = 1'b0;
    model_byte(b, bad);
    repeat (6) @(posedge ext_clk);
    #1;
    oib_clk  = 1'b0;
    check_en = 1'b1;
    repeat (6) @(posedge ext_clk);
    #1;
  endtask

  task automatic wr_frame(input logic [7:0] a, input logic [31:0] d);
    send(8'h01, 1'b0);
    send(a, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    for (int k = 0; k < 4; k++) send(8'((d >> (8 * k)) & 32'hFF), 1'b0);
  endtask

  task automatic rd_frame(input logic [7:0] a);
    send(8'h02, 1'b0);
    send(a, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
  endtask

  task automatic rd_check(input logic [7:0] a, input logic [31:0] w);
    rd_frame(a);
    send(8'h00, 1'b0);
    expect_lit("rd_hdr", 0, 8'h81);
    for (int k = 0; k < 4; k++) begin
      send(8'h00, 1'b0);
      expect_lit("rd_byte", 0, 8'((w >> (8 * k)) & 32'hFF));
    end
    send(8'h00, 1'b0);
    expect_lit("rd_idle", 0, 8'h00);
    expect_lit("rd_busy_low", 1, 8'h00);
  endtask

  logic [7:0] fb [$];
  int         kind;
  int         badpos;
  logic [7:0] rb;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    check_en  = 1'b0;
    lit_req   = 1'b0;
    ext_rst_n = 1'b0;
    oib_clk   = 1'b0;
    ob_data   = 8'h00;
    ob_pty    = 1'b0;
    model_reset();

    // Reset held while the strobe toggles.
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(posedge ext_clk);
      #1;
      oib_clk = ~oib_clk;
    end
    expect_lit("rst_ib", 0, 8'h00);
    expect_lit("rst_pty", 3, 8'h00);
    expect_lit("rst_busy", 1, 8'h00);
    expect_lit("rst_err", 2, 8'h00);
    oib_clk = 1'b0;
    repeat (2) @(posedge ext_clk);
    #1;
    ext_rst_n = 1'b1;
    repeat (4) @(posedge ext_clk);
    #1;
    check_en = 1'b1;

    rd_check(8'h05, 32'h0);

    wr_frame(8'h03, 32'hDEADBEEF);
    send(8'h00, 1'b0);
    expect_lit("wr_ack", 0, 8'h80);
    expect_lit("wr_busy", 1, 8'h01);
    send(8'h00, 1'b0);
    expect_lit("wr_busy_low", 1, 8'h00);
    rd_check(8'h03, 32'hDEADBEEF);

    wr_frame(8'h13, 32'h11223344);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    rd_check(8'h03, 32'h11223344);

    // Parity error on A2 of a write to word 7.
    send(8'h01, 1'b0);
    send(8'h07, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b1);
    send(8'h00, 1'b0);
    expect_lit("par_rsp", 0, 8'hFF);
    expect_lit("par_err", 2, 8'h01);
    send(8'h00, 1'b0);
    rd_check(8'h07, 32'h0);

    for (int i = 0; i < 256; i++) begin
      send(8'h05, 1'b0);
      send(8'h00, 1'b0);
      if (i == 0) expect_lit("bad_rsp", 0, 8'hFF);
      send(8'h00, 1'b0);
    end
    expect_lit("err_sat", 2, 8'hFF);

    // Reset after D1 of a write.
    send(8'h01, 1'b0);
    send(8'h04, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    ext_rst_n = 1'b0;
    check_en  = 1'b0;
    model_reset();
    expect_lit("mid_rst_busy", 1, 8'h00);
    expect_lit("mid_rst_err", 2, 8'h00);
    repeat (2) @(posedge ext_clk);
    #1;
    ext_rst_n = 1'b1;
    repeat (4) @(posedge ext_clk);
    #1;
    check_en = 1'b1;
    rd_check(8'h04, 32'h0);

    // Randomised frames against the model.
    for (int f = 0; f < 150; f++) begin
      fb.delete();
      kind   = $urandom_range(0, 9);
      badpos = -1;
      if (kind < 4) begin
        fb.push_back(8'h01);
        for (int k = 0; k < 8; k++) fb.push_back(8'($urandom_range(0, 255)));
      end else if (kind < 8) begin
        fb.push_back(8'h02);
        for (int k = 0; k < 4; k++) fb.push_back(8'($urandom_range(0, 255)));
      end else if (kind == 8) begin
        fb.push_back(8'h00);
      end else begin
        rb = 8'($urandom_range(3, 255));
        fb.push_back(rb);
      end
      if ($urandom_range(0, 7) == 0) badpos = $urandom_range(0, fb.size() - 1);
      foreach (fb[i]) begin
        if (m_resp) break;
        send(fb[i], (i == badpos));
      end
      for (int k = 0; k < 8 && exp_busy; k++) send(8'h00, 1'b0);
    end

    @(negedge ext_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
